scdpram_reader: RTL and testbench
=================================

SCDPRAM_READER -- requirements
Module: scdpram_reader

Interface
REQ-001 Parameter: WIDTH, 10, data word width in bits.
REQ-002 Parameter: ADDR, 4, read address width; memory depth 2**ADDR.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_start  input  1  start-of-burst request; sampled only in IDLE.
REQ-006 i_base_addr  input  ADDR  first address of burst; captured with i_start.
REQ-007 i_count  input  ADDR+1  burst length in words, 0..2**ADDR; captured with i_start.
REQ-008 o_busy  output  1  high while a burst is in progress.
REQ-009 o_rd_addr  output  ADDR  read address to the synchronous-read RAM port.
REQ-010 i_rd_data  input  WIDTH  RAM read data; valid in the cycle after the address was presented.
REQ-011 o_data  output  WIDTH  stream data, head of output buffer.
REQ-012 o_valid  output  1  stream data valid.
REQ-013 i_ready  input  1  downstream accept; transfer = o_valid & i_ready on a rising edge.
REQ-014 o_done  output  1  one-cycle pulse, burst complete.

Function
REQ-015 States: IDLE, RUN; IDLE->RUN on i_start in IDLE; RUN->IDLE on the edge accepting the final word; i_start in RUN is ignored.
REQ-016 Issue: in cycle N with RUN, remaining-to-issue > 0 and (buffer occupancy + in-flight - pop_this_cycle) < 2, the block issues one read; o_rd_addr is driven combinationally to the next issue address.
REQ-017 The RAM registers o_rd_addr at the end of issue cycle N; i_rd_data is captured into the output buffer at the end of cycle N+1 (in-flight count ≤ 1 per issue).
REQ-018 Addresses increment by 1 modulo 2**ADDR from i_base_addr (wrap 2**ADDR-1 -> 0).
REQ-019 Output buffer: 2-entry FIFO; o_valid = occupancy > 0; o_data = head entry; head entry and o_valid hold stable while o_valid & !i_ready.
REQ-020 Buffer occupancy + in-flight reads never exceeds 2; no word is dropped or duplicated under any i_ready pattern.
REQ-021 With i_ready held high, words stream at one per cycle; first o_valid appears in the second cycle after the start edge.
REQ-022 Simultaneous capture and pop in one cycle: occupancy unchanged, order preserved.
REQ-023 o_busy high from the cycle after the start edge until the cycle o_done pulses (inclusive of the last transfer cycle, exclusive of the o_done cycle).
REQ-024 o_done pulses for exactly one cycle in the cycle after the final transfer; o_busy is low in that cycle.
REQ-025 i_count = 0: no reads issued, no o_valid; o_done pulses in the cycle after the start edge.
REQ-026 i_count = 2**ADDR: every address read exactly once, starting at i_base_addr with wrap.
REQ-027 When not issuing, o_rd_addr holds its last driven value.
REQ-028 i_start in the same cycle as o_done is accepted (state is IDLE).

Reset
REQ-029 On i_reset_n low, immediately and asynchronously: state IDLE, o_busy 0, o_valid 0, o_done 0, o_rd_addr 0, o_data 0, buffer and in-flight cleared.
REQ-030 Reset mid-burst discards all buffered and in-flight data; no o_done is produced for the aborted burst.
REQ-031 After release, the block accepts i_start on the first rising edge.

Verification
REQ-032 RAM preloaded mem[a]=3*a; start base 2, count 4, i_ready=1 -> o_data 6,9,12,15 on consecutive cycles, first o_valid 2 cycles after start edge, o_done one cycle after 15 accepted.
REQ-033 Wrap: base 14, count 4 -> o_rd_addr sequence 14,15,0,1; o_data 42,45,0,3.
REQ-034 Backpressure: count 8, i_ready random/toggling -> exactly 8 ordered words, o_data stable while stalled, occupancy+in-flight ≤ 2 asserted every cycle.
REQ-035 count 0 -> o_done one cycle after start edge, o_valid never high; count 16 -> 16 words, each address once.
REQ-036 i_start pulsed mid-burst -> ignored, burst completes unchanged; i_reset_n low mid-burst -> all outputs 0 immediately, no o_done, next burst correct.

Source files
------------

// File: rtl/scdpram_reader_if.sv
// -----------------------------------------------------------------------------
// scdpram_reader_if
// Bundles the burst-control, RAM read port and output stream signals of
// scdpram_reader so they travel through a single port.
//   i_start / i_base_addr / i_count : burst request (sampled in IDLE)
//   o_busy / o_done                  : burst status, done is a 1-cycle pulse
//   o_rd_addr / i_rd_data            : synchronous-read RAM port (1-cycle latency)
//   o_data / o_valid / i_ready       : output stream, transfer = o_valid & i_ready
// slave  : the reader block itself
// master : the environment (requester, RAM and stream sink)
// -----------------------------------------------------------------------------
interface scdpram_reader_if #(
  parameter int WIDTH = 10,
  parameter int ADDR  = 4
) ();
  logic             i_start;
  logic [ADDR-1:0]  i_base_addr;
  logic [ADDR:0]    i_count;
  logic             o_busy;
  logic [ADDR-1:0]  o_rd_addr;
  logic [WIDTH-1:0] i_rd_data;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_done;

  modport slave (
    input  i_start, i_base_addr, i_count, i_rd_data, i_ready,
    output o_busy, o_rd_addr, o_data, o_valid, o_done
  );

  modport master (
    output i_start, i_base_addr, i_count, i_rd_data, i_ready,
    input  o_busy, o_rd_addr, o_data, o_valid, o_done
  );
endinterface

// File: rtl/scdpram_reader.sv
// -----------------------------------------------------------------------------
// scdpram_reader
// Reads a burst of i_count consecutive words (address wraps modulo 2**ADDR)
// from a synchronous-read RAM starting at i_base_addr and streams them out
// through a 2-entry buffer with valid/ready flow control.
// Ports:
//   clk       : clock, all state on the rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : scdpram_reader_if.slave (request, RAM port, stream, status)
// -----------------------------------------------------------------------------
module scdpram_reader #(
  parameter int WIDTH = 10,
  parameter int ADDR  = 4
) (
  input  logic               clk,
  input  logic               i_reset_n,
  scdpram_reader_if.slave    bus
);

  localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
  localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;          // next address to issue
  logic [ADDR-1:0]  rd_addr_q, rd_addr_d;    // last issued address
  logic [ADDR:0]    issue_rem_q, issue_rem_d;
  logic [ADDR:0]    xfer_rem_q, xfer_rem_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;          // head entry
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic             done_q, done_d;

  logic             pop;
  logic             capture;
  logic             issue;
  logic [2:0]       pend;

  always_comb begin
    pop     = (occ_q != 2'd0) & bus.i_ready;
    capture = inflight_q;
    // Slots already claimed after this cycle's pop; a new read may only be
    // issued if its word is guaranteed a buffer slot on arrival.
    pend    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == RUN) && (issue_rem_q != '0) && (pend < 3'd2);

    state_d     = state_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    issue_rem_d = issue_rem_q;
    xfer_rem_d  = xfer_rem_q;
    done_d      = 1'b0;

    if (state_q == IDLE) begin
      if (bus.i_start) begin
        addr_d      = bus.i_base_addr;
        issue_rem_d = bus.i_count;
        xfer_rem_d  = bus.i_count;
        // An empty burst completes immediately without entering RUN.
        if (bus.i_count == '0) done_d  = 1'b1;
        else                   state_d = RUN;
      end
    end else begin
      if (issue) begin
        addr_d      = addr_q + ADDR_ONE;
        rd_addr_d   = addr_q;
        issue_rem_d = issue_rem_q - CNT_ONE;
      end
      if (pop) begin
        xfer_rem_d = xfer_rem_q - CNT_ONE;
        if (xfer_rem_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end

    inflight_d = issue;

    // Output buffer: the RAM word arriving this cycle lands behind whatever
    // remains after the pop, so order is kept on simultaneous capture/pop.
    occ_d  = occ_q + {1'b0, capture} - {1'b0, pop};
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({capture, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.i_rd_data;
        else               buf1_d = bus.i_rd_data;
      end
      2'b01: begin
        if (occ_q == 2'd2) buf0_d = buf1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.i_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.i_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      issue_rem_q <= '0;
      xfer_rem_q  <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      issue_rem_q <= issue_rem_d;
      xfer_rem_q  <= xfer_rem_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      done_q      <= done_d;
    end
  end

  // The address reaches the RAM in the issue cycle itself; otherwise the
  // port keeps showing the last issued address.
  assign bus.o_rd_addr = issue ? addr_q : rd_addr_q;
  assign bus.o_busy    = (state_q == RUN);
  assign bus.o_valid   = (occ_q != 2'd0);
  assign bus.o_data    = buf0_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_scdpram_reader.sv
// -----------------------------------------------------------------------------
// tb_scdpram_reader
// Scoreboard bench: each burst pushes its expected words (mem[a] = 3*a) into
// a queue; a negedge monitor pops and compares on every transfer and tracks
// the o_done pulse, stall stability and buffer occupancy.
// -----------------------------------------------------------------------------
module tb_scdpram_reader;
  localparam int WIDTH = 10;
  localparam int ADDR  = 4;

  logic clk = 1'b0;
  logic i_reset_n;

  scdpram_reader_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  scdpram_reader #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [0:15];
  always @(posedge clk) bus.i_rd_data <= mem[bus.o_rd_addr];

  int               sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               exp_done_next = 1'b0;
  bit               done_seen = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled mid-cycle; a transfer seen here happens on the
  // following rising edge, so o_done is due at the next monitor sample.
  always @(negedge clk) begin
    if (i_reset_n) begin
      int e;
      bit occ_ok;
      chk("done_pulse", int'(bus.o_done), int'(exp_done_next));
      if (exp_done_next) begin
        chk("busy_at_done", int'(bus.o_busy), 0);
        done_seen     = 1'b1;
        exp_done_next = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(bus.o_valid), 1);
        chk("stall_data", int'(bus.o_data), int'(prev_data));
      end
      if (sb.size() == 0) chk("valid_idle", int'(bus.o_valid), 0);
      if (bus.o_valid && bus.i_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("data", int'(bus.o_data), e);
        if (sb.size() == 0) exp_done_next = 1'b1;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      occ_ok = (int'(dut.occ_q) + int'(dut.inflight_q)) <= 2;
      chk("occ_inflight_le2", int'(occ_ok), 1);
    end
  end

  // Starts a burst at the current time (1 unit after a rising edge) and
  // drives i_ready until the burst's o_done has been checked.
  // mode: 0 ready high, 1 toggling, 2 fixed irregular pattern.
  task automatic run_burst(input int b, input int c, input int mode,
                           input bit lat, input bit early, input bit poke);
    bit          fin;
    logic [15:0] pat;
    pat = 16'b1101_0011_1000_1011;
    bus.i_start     = 1'b1;
    bus.i_base_addr = ADDR'(b);
    bus.i_count     = (ADDR+1)'(c);
    for (int i = 0; i < c; i++) sb.push_back(3 * ((b + i) % 16));
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    done_seen   = 1'b0;
    if (c == 0) exp_done_next = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (lat) begin
        if (k == 0 && c == 0) begin
          chk("done_cnt0", int'(bus.o_done), 1);
          chk("busy_cnt0", int'(bus.o_busy), 0);
        end
        if (k == 1) begin
          chk("valid_k1", int'(bus.o_valid), 0);
          chk("busy_k1", int'(bus.o_busy), (c > 0) ? 1 : 0);
        end
        if (k == 2 && c > 0) chk("valid_k2", int'(bus.o_valid), 1);
        if (c > 0 && k == c + 2) begin
          chk("done_time", int'(bus.o_done), 1);
          chk("busy_done_time", int'(bus.o_busy), 0);
        end
      end
      if (poke) begin
        if (k == 3) begin
          bus.i_start     = 1'b1;
          bus.i_base_addr = ADDR'(9);
          bus.i_count     = (ADDR+1)'(3);
        end else begin
          bus.i_start = 1'b0;
        end
      end
      case (mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ((k & 1) != 0);
        default: bus.i_ready = pat[k % 16];
      endcase
      if (early && c > 0 && k == c + 2) begin fin = 1'b1; break; end
      if (done_seen) begin fin = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!fin) begin
      chk("burst_timeout", 0, 1);
      sb.delete();
      exp_done_next = 1'b0;
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = WIDTH'(3 * a);
    i_reset_n       = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_count     = '0;
    bus.i_ready     = 1'b0;

    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_busy",    int'(bus.o_busy),    0);
    chk("rst_valid",   int'(bus.o_valid),   0);
    chk("rst_done",    int'(bus.o_done),    0);
    chk("rst_rd_addr", int'(bus.o_rd_addr), 0);
    chk("rst_data",    int'(bus.o_data),    0);
    repeat (3) @(posedge clk);
    #1 i_reset_n = 1'b1;

    // Start on the first edge after release; 6,9,12,15 back to back.
    run_burst(2, 4, 0, 1'b1, 1'b0, 1'b0);
    // Wrap 14,15,0,1, then an empty burst started in the o_done cycle.
    run_burst(14, 4, 0, 1'b1, 1'b1, 1'b0);
    run_burst(0, 0, 0, 1'b1, 1'b0, 1'b0);
    // Backpressure with a start pulse in the middle that must be ignored.
    run_burst(5, 8, 1, 1'b0, 1'b0, 1'b1);
    run_burst(11, 8, 2, 1'b0, 1'b0, 1'b0);
    // Full-depth bursts: every address once, wrapping from the base.
    run_burst(7, 16, 2, 1'b0, 1'b0, 1'b0);
    run_burst(3, 16, 0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    bus.i_start     = 1'b1;
    bus.i_base_addr = ADDR'(4);
    bus.i_count     = (ADDR+1)'(8);
    for (int i = 0; i < 8; i++) sb.push_back(3 * ((4 + i) % 16));
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (4) begin
      bus.i_ready = ~bus.i_ready;
      @(posedge clk); #1;
    end
    chk("busy_before_abort", int'(bus.o_busy), 1);
    #2 i_reset_n = 1'b0;
    sb.delete();
    exp_done_next = 1'b0;
    prev_stall    = 1'b0;
    #1;
    chk("abort_busy",    int'(bus.o_busy),    0);
    chk("abort_valid",   int'(bus.o_valid),   0);
    chk("abort_done",    int'(bus.o_done),    0);
    chk("abort_rd_addr", int'(bus.o_rd_addr), 0);
    chk("abort_data",    int'(bus.o_data),    0);
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b1;
    run_burst(1, 5, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
